str_op_ctrl: RTL

STR_OP_CTRL -- requirements
Module: str_op_ctrl

---
 rtl/str_op_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/str_op_ctrl.sv
// -----------------------------------------------------------------------------
// str_op_ctrl
//   Command/response controller for two small character-string buffers (A, B).
//   Single-cycle ops (append, clear, putc, getc, reserved) answer the cycle
//   after acceptance. COMPARE walks both strings one character pair per
//   cycle. TOLOWER_A walks A one character per cycle.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op               0 APPEND_A, 1 APPEND_B, 2 CLEAR, 3 COMPARE,
//                        4 PUTC_A, 5 GETC_A, 6 TOLOWER_A, 7 reserved
//   cmd_idx, cmd_char    index for PUTC/GETC, character for APPEND/PUTC
//   rsp_valid/rsp_ready  response handshake; fields held until consumed
//   rsp_data             GETC character, else 0
//   rsp_cmp              00 EQ, 01 LT (A<B), 10 GT
//   rsp_err              command rejected, buffers unchanged
//   len_a, len_b         current string lengths (0..DEPTH)
// -----------------------------------------------------------------------------
module str_op_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_idx,
  input  logic [7:0]    cmd_char,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [1:0]    rsp_cmp,
  output logic          rsp_err,
  output logic [AW:0]   len_a,
  output logic [AW:0]   len_b
);

  localparam logic [2:0] OP_APPA  = 3'd0;
  localparam logic [2:0] OP_APPB  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_CMP   = 3'd3;
  localparam logic [2:0] OP_PUTC  = 3'd4;
  localparam logic [2:0] OP_GETC  = 3'd5;
  localparam logic [2:0] OP_LOWER = 3'd6;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_LOWER, S_RESP} state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_data;
  logic [1:0]    r_rsp_cmp;
  logic          r_rsp_err;
  logic [AW:0]   r_len_a;
  logic [AW:0]   r_len_b;
  // walk index; one bit wider than AW because it must reach len == DEPTH
  logic [AW:0]   r_i;

  // buffer storage is intentionally not reset: contents past len are don't-care
  logic [7:0]    r_buf_a [DEPTH];
  logic [7:0]    r_buf_b [DEPTH];

  logic          w_accept;
  logic [7:0]    w_ai, w_bi, w_a_idx, w_lower;
  logic          w_idx_ok, w_a_full, w_b_full;
  logic          w_cmp_done;
  logic [1:0]    w_cmp_code;
  logic          w_a_we, w_b_we;
  logic [AW-1:0] w_a_waddr, w_b_waddr;
  logic [7:0]    w_a_wdata, w_b_wdata;

  // r_cmd_ready is only high in IDLE, so it doubles as the accept qualifier
  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_ai     = r_buf_a[r_i[AW-1:0]];
  assign w_bi     = r_buf_b[r_i[AW-1:0]];
  assign w_a_idx  = r_buf_a[cmd_idx];
  assign w_idx_ok = ({1'b0, cmd_idx} < r_len_a);
  assign w_a_full = (r_len_a == FULL);
  assign w_b_full = (r_len_b == FULL);
  assign w_lower  = (w_ai >= 8'h41 && w_ai <= 8'h5A) ? (w_ai + 8'h20) : w_ai;

  // compare rules evaluated in priority order for the current index
  always_comb begin
    w_cmp_done = 1'b1;
    w_cmp_code = CMP_EQ;
    if (r_i == r_len_a && r_i == r_len_b) w_cmp_code = CMP_EQ;
    else if (r_i == r_len_a)              w_cmp_code = CMP_LT;
    else if (r_i == r_len_b)              w_cmp_code = CMP_GT;
    else if (w_ai < w_bi)                 w_cmp_code = CMP_LT;
    else if (w_ai > w_bi)                 w_cmp_code = CMP_GT;
    else                                  w_cmp_done = 1'b0;
  end

  // buffer write ports
  always_comb begin
    w_a_we    = 1'b0;
    w_a_waddr = '0;
    w_a_wdata = '0;
    w_b_we    = 1'b0;
    w_b_waddr = '0;
    w_b_wdata = '0;
    if (w_accept) begin
      case (cmd_op)
        OP_APPA: if (!w_a_full) begin
          w_a_we    = 1'b1;
          w_a_waddr = r_len_a[AW-1:0];
          w_a_wdata = cmd_char;
        end
        OP_APPB: if (!w_b_full) begin
          w_b_we    = 1'b1;
          w_b_waddr = r_len_b[AW-1:0];
          w_b_wdata = cmd_char;
        end
        OP_PUTC: if (w_idx_ok && cmd_char != 8'h00) begin
          w_a_we    = 1'b1;
          w_a_waddr = cmd_idx;
          w_a_wdata = cmd_char;
        end
        default: ;
      endcase
    end else if (r_state == S_LOWER) begin
      w_a_we    = 1'b1;
      w_a_waddr = r_i[AW-1:0];
      w_a_wdata = w_lower;
    end
  end

  always_ff @(posedge clk) begin
    if (w_a_we) r_buf_a[w_a_waddr] <= w_a_wdata;
    if (w_b_we) r_buf_b[w_b_waddr] <= w_b_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_cmp   <= CMP_EQ;
      r_rsp_err   <= 1'b0;
      r_len_a     <= '0;
      r_len_b     <= '0;
      r_i         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_cmp   <= CMP_EQ;
            r_rsp_err   <= 1'b0;
            case (cmd_op)
              OP_APPA: if (w_a_full) r_rsp_err <= 1'b1;
                       else          r_len_a   <= r_len_a + ONE;
              OP_APPB: if (w_b_full) r_rsp_err <= 1'b1;
                       else          r_len_b   <= r_len_b + ONE;
              OP_CLEAR: begin
                r_len_a <= '0;
                r_len_b <= '0;
              end
              OP_CMP: begin
                r_state     <= S_CMP;
                r_rsp_valid <= 1'b0;
                r_i         <= '0;
              end
              OP_PUTC: if (!w_idx_ok || cmd_char == 8'h00) r_rsp_err <= 1'b1;
              OP_GETC: if (w_idx_ok) r_rsp_data <= w_a_idx;
                       else          r_rsp_err  <= 1'b1;
              OP_LOWER: if (r_len_a != '0) begin
                r_state     <= S_LOWER;
                r_rsp_valid <= 1'b0;
                r_i         <= '0;
              end
              default: r_rsp_err <= 1'b1;
            endcase
          end else begin
            // also raises ready on the first edge after reset release
            r_cmd_ready <= 1'b1;
          end
        end
        S_CMP: begin
          if (w_cmp_done) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_cmp   <= w_cmp_code;
          end else begin
            r_i <= r_i + ONE;
          end
        end
        S_LOWER: begin
          if (r_i == r_len_a - ONE) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_i <= r_i + ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_cmp   <= CMP_EQ;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_cmp   = r_rsp_cmp;
  assign rsp_err   = r_rsp_err;
  assign len_a     = r_len_a;
  assign len_b     = r_len_b;

endmodule
